fetch_pc_unit: RTL

Program-counter and instruction-fetch front end; it consumes the target address produced by the jump/branch logic. Holds the architectural fetch PC, issues in-order requests to instruction memory over a valid/ready interface, and buffers returned instructions (2 entries) toward decode. On a redirect it flushes buffered instructions and discards in-flight responses from the old path.

---
 rtl/fetch_pc_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests and
// holds up to two returned instructions for decode. A redirect abandons the old path.
module fetch_pc_unit #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    // Handshakes: imem_req and id transfer on a rising edge where valid and ready are
    // both high; valid never waits for ready. imem_rsp has no ready and is never refused.

    logic [XLEN-1:0] pc;
    logic [1:0]      inflight;
    logic [1:0]      stale;
    logic [1:0]      buf_count;
    logic [XLEN-1:0] iss_pc [2];
    logic [ILEN-1:0] buf_instr [2];
    logic [XLEN-1:0] buf_pc [2];

    logic       req_fire;
    logic       id_fire;
    logic       rsp_drop;
    logic       rsp_push;
    logic [1:0] iss_keep;
    logic [1:0] inflight_nxt;
    logic [1:0] buf_keep;
    logic [2:0] credit_used;
    logic       unused_redirect_low;

    assign unused_redirect_low = ^redirect_addr[1:0];

    assign id_valid      = (buf_count != 2'd0);
    assign id_fire       = id_valid & id_ready;
    assign id_instr      = buf_instr[0];
    assign id_pc         = buf_pc[0];
    assign imem_req_addr = pc;

    // A slot freed by this cycle's decode pop may be reused by a request issued now.
    always_comb begin
        credit_used = {1'b0, inflight} + {1'b0, buf_count} - {2'b00, id_fire};
    end

    assign imem_req_valid = !rst && (credit_used < 3'd2);
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (stale != 2'd0);
    assign rsp_push       = imem_rsp_valid && (stale == 2'd0);

    always_comb begin
        iss_keep     = inflight - {1'b0, imem_rsp_valid};
        inflight_nxt = iss_keep + {1'b0, req_fire};
        buf_keep     = buf_count - {1'b0, id_fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_ADDR;
            inflight  <= 2'd0;
            stale     <= 2'd0;
            buf_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                iss_pc[i]    <= '0;
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_addr[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end

            inflight <= inflight_nxt;

            // Everything still outstanding after this cycle belongs to the old path.
            if (redirect_valid) begin
                stale <= inflight_nxt;
            end else if (rsp_drop) begin
                stale <= stale - 2'd1;
            end

            // Shift-style FIFOs: pop moves entry 1 down, push lands behind what remains.
            if (imem_rsp_valid) begin
                iss_pc[0] <= iss_pc[1];
            end
            if (req_fire) begin
                iss_pc[iss_keep[0]] <= pc;
            end

            if (id_fire) begin
                buf_instr[0] <= buf_instr[1];
                buf_pc[0]    <= buf_pc[1];
            end
            if (rsp_push) begin
                buf_instr[buf_keep[0]] <= imem_rsp_data;
                buf_pc[buf_keep[0]]    <= iss_pc[0];
            end

            if (redirect_valid) begin
                buf_count <= 2'd0;
            end else begin
                buf_count <= buf_keep + {1'b0, rsp_push};
            end
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (inflight != 2'd0));

    a_buffer_no_overflow: assert property (@(posedge clk) disable iff (rst)
        rsp_push |-> (buf_keep != 2'd2));

endmodule
